// File: rtl/sensor_interval_timer.sv
// S1->S2 crossing interval timer: synchronises and debounces both track sensors,
// then measures the gap in 1 ms ticks for the arrival-time predictor.
module sensor_interval_timer #(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int TICK_DIV        = CLK_FREQ_HZ / 1000,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int TIMEOUT_MS      = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sensor_s1,
  input  logic        sensor_s2,
  output logic [18:0] time_ms,
  output logic        time_valid,
  output logic        timeout,
  output logic        seq_err,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for an S1 edge; S2 edges here are sequence errors
  // TIMING | prescaler running, ms_count accumulating until S2 or timeout
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] TIMING = 1'b1;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [18:0]   MS_LIMIT  = 19'(TIMEOUT_MS);

  // index 0 = S1, index 1 = S2
  logic [1:0]    meta_q, meta_d;
  logic [1:0]    sync_q, sync_d;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_dly_q, deb_dly_d;
  logic [1:0]    edge_q, edge_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [18:0]   ms_count_q, ms_count_d;
  logic [18:0]   time_ms_q, time_ms_d;
  logic          time_valid_q, time_valid_d;
  logic          timeout_q, timeout_d;
  logic          seq_err_q, seq_err_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic [18:0]   ms_next;

  always_comb begin
    meta_d    = {sensor_s2, sensor_s1};
    sync_d    = meta_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    edge_d    = deb_q & ~deb_dly_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign tick    = (state_q == TIMING) && (presc_q == TICK_LAST);
  assign ms_next = ms_count_q + 19'(tick);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    ms_count_d   = ms_count_q;
    time_ms_d    = time_ms_q;
    time_valid_d = 1'b0;
    timeout_d    = 1'b0;
    seq_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // S1 wins a simultaneous S1/S2 edge
        if (edge_q[0]) begin
          state_d    = TIMING;
          presc_d    = '0;
          ms_count_d = '0;
        end else if (edge_q[1]) begin
          seq_err_d = 1'b1;
        end
      end
      default: begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        ms_count_d = ms_next;
        // S1 re-edges from trailing axles are ignored; S2 beats timeout on a tie
        if (edge_q[1]) begin
          time_ms_d    = (ms_next == '0) ? 19'd1 : ms_next;
          time_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (ms_next == MS_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
    busy_d = (state_d == TIMING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q       <= '0;
      sync_q       <= '0;
      deb_q        <= '0;
      deb_dly_q    <= '0;
      edge_q       <= '0;
      db_cnt_q[0]  <= '0;
      db_cnt_q[1]  <= '0;
      state_q      <= IDLE;
      presc_q      <= '0;
      ms_count_q   <= '0;
      time_ms_q    <= '0;
      time_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      deb_q        <= deb_d;
      deb_dly_q    <= deb_dly_d;
      edge_q       <= edge_d;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
      state_q      <= state_d;
      presc_q      <= presc_d;
      ms_count_q   <= ms_count_d;
      time_ms_q    <= time_ms_d;
      time_valid_q <= time_valid_d;
      timeout_q    <= timeout_d;
      seq_err_q    <= seq_err_d;
      busy_q       <= busy_d;
    end
  end

  assign time_ms    = time_ms_q;
  assign time_valid = time_valid_q;
  assign timeout    = timeout_q;
  assign seq_err    = seq_err_q;
  assign busy       = busy_q;

endmodule
